// File: rtl/cfg_lut_bank.sv
// Bank of K-input LUTs configured through a serial shadow chain; a commit strobe
// swaps the whole shadow image into the active tables in one cycle.
module cfg_lut_bank #(
   parameter int K        = 2,
   parameter int NUM_LUTS = 4
) (
   input  logic                                        clock,
   input  logic                                        reset,
   input  logic                                        config_valid,
   input  logic                                        config_in,
   input  logic                                        commit,
   input  logic [NUM_LUTS*K-1:0]                       select,
   output logic                                        config_out,
   output logic [$clog2(NUM_LUTS*(2**K+1)+1)-1:0]      config_count,
   output logic                                        config_full,
   output logic                                        commit_err,
   output logic                                        active_valid,
   output logic [NUM_LUTS-1:0]                         lut_out
);

   localparam int TBL   = 2**K;
   localparam int FRAME = TBL + 1;
   localparam int TOTAL = NUM_LUTS * FRAME;
   localparam int CW    = $clog2(TOTAL + 1);
   localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   logic [TOTAL-1:0]               shadow_q, shadow_d;
   logic [CW-1:0]                  count_q, count_d;
   logic [NUM_LUTS-1:0][TBL-1:0]   tbl_q, tbl_d;
   logic [NUM_LUTS-1:0]            mode_q, mode_d;
   logic                           active_valid_q, active_valid_d;
   logic                           commit_err_q, commit_err_d;
   logic [NUM_LUTS-1:0]            lut_reg_q, lut_reg_d;

   logic [NUM_LUTS-1:0][TBL-1:0]   new_tbl_s;
   logic [NUM_LUTS-1:0]            new_mode_s;
   logic [NUM_LUTS-1:0][K-1:0]     sel_s;
   logic [NUM_LUTS-1:0]            lookup_s;
   logic                           full_s;
   logic                           commit_ok_s;

   genvar g;
   generate
      for (g = 0; g < NUM_LUTS; g++) begin : g_lut
         assign new_tbl_s[g]  = shadow_q[g*FRAME +: TBL];
         assign new_mode_s[g] = shadow_q[g*FRAME + TBL];
         assign sel_s[g]      = select[g*K +: K];
         // Unconfigured bank drives zeros regardless of stale table contents.
         assign lookup_s[g]   = active_valid_q & tbl_q[g][sel_s[g]];
         assign lut_out[g]    = mode_q[g] ? lut_reg_q[g] : lookup_s[g];
      end
   endgenerate

   assign full_s       = (count_q == TOTAL_C);
   assign commit_ok_s  = commit & full_s;
   assign config_out   = shadow_q[TOTAL-1];
   assign config_count = count_q;
   assign config_full  = full_s;
   assign commit_err   = commit_err_q;
   assign active_valid = active_valid_q;

   // Next-state: shadow shift, load counter, commit transfer and error pulse.
   always_comb begin
      shadow_d       = shadow_q;
      count_d        = count_q;
      tbl_d          = tbl_q;
      mode_d         = mode_q;
      active_valid_d = active_valid_q;
      commit_err_d   = commit & ~full_s;
      lut_reg_d      = lookup_s;

      if (config_valid) begin
         shadow_d = {shadow_q[TOTAL-2:0], config_in};
      end else begin
         shadow_d = shadow_q;
      end

      // A shift coinciding with a commit becomes the first bit of the next load.
      if (commit_ok_s) begin
         tbl_d          = new_tbl_s;
         mode_d         = new_mode_s;
         active_valid_d = 1'b1;
         if (config_valid) begin
            count_d = ONE_C;
         end else begin
            count_d = '0;
         end
      end else if (config_valid && !full_s) begin
         count_d = count_q + ONE_C;
      end else begin
         count_d = count_q;
      end
   end

   // State registers, all cleared by the asynchronous reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shadow_q       <= '0;
         count_q        <= '0;
         tbl_q          <= '0;
         mode_q         <= '0;
         active_valid_q <= 1'b0;
         commit_err_q   <= 1'b0;
         lut_reg_q      <= '0;
      end else begin
         shadow_q       <= shadow_d;
         count_q        <= count_d;
         tbl_q          <= tbl_d;
         mode_q         <= mode_d;
         active_valid_q <= active_valid_d;
         commit_err_q   <= commit_err_d;
         lut_reg_q      <= lut_reg_d;
      end
   end

endmodule

// File: tb/tb_cfg_lut_bank.sv
// Directed bench for cfg_lut_bank with K=2, NUM_LUTS=2 (FRAME=5, TOTAL=10).
module tb_cfg_lut_bank;

   logic       clock = 1'b0;
   logic       reset;
   logic       config_valid;
   logic       config_in;
   logic       commit;
   logic [3:0] select;
   logic       config_out;
   logic [3:0] config_count;
   logic       config_full;
   logic       commit_err;
   logic       active_valid;
   logic [1:0] lut_out;

   int vectors = 0;
   int miscompares = 0;

   cfg_lut_bank #(.K(2), .NUM_LUTS(2)) dut (
      .clock        (clock),
      .reset        (reset),
      .config_valid (config_valid),
      .config_in    (config_in),
      .commit       (commit),
      .select       (select),
      .config_out   (config_out),
      .config_count (config_count),
      .config_full  (config_full),
      .commit_err   (commit_err),
      .active_valid (active_valid),
      .lut_out      (lut_out)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic shift_bit(input logic b);
      config_valid = 1'b1;
      config_in    = b;
      step();
      config_valid = 1'b0;
      config_in    = 1'b0;
   endtask

   logic [9:0]  s1 = 10'b1011001000;    // first-sent bit is [9]
   logic [11:0] ovf = 12'b010111010111;
   logic [9:0]  s3 = 10'b0100100010;
   logic [3:0]  exp_and = 4'b1000;
   logic [3:0]  exp_xor = 4'b0110;
   logic [1:0]  sv;

   initial begin
      reset = 1'b1; config_valid = 1'b0; config_in = 1'b0; commit = 1'b0; select = 4'b0000;
      #2;
      chk("rst_count",  32'(config_count), 32'd0);
      chk("rst_full",   32'(config_full),  32'd0);
      chk("rst_out",    32'(config_out),   32'd0);
      chk("rst_err",    32'(commit_err),   32'd0);
      chk("rst_avalid", 32'(active_valid), 32'd0);
      chk("rst_lut",    32'(lut_out),      32'd0);
      step();
      reset = 1'b0;

      shift_bit(1'b1);
      chk("cnt_after1", 32'(config_count), 32'd1);
      #3 reset = 1'b1;
      #1;
      chk("async_rst_cnt", 32'(config_count), 32'd0);
      reset = 1'b0;

      // Stream 1 with an early commit after six bits
      for (int i = 9; i >= 4; i--) shift_bit(s1[i]);
      chk("cnt6", 32'(config_count), 32'd6);
      chk("full6", 32'(config_full), 32'd0);
      commit = 1'b1;
      step();
      commit = 1'b0;
      chk("early_err",    32'(commit_err),   32'd1);
      chk("early_cnt",    32'(config_count), 32'd6);
      chk("early_avalid", 32'(active_valid), 32'd0);
      chk("early_lut",    32'(lut_out),      32'd0);
      step();
      chk("err_pulse_end", 32'(commit_err), 32'd0);
      for (int i = 3; i >= 0; i--) shift_bit(s1[i]);
      chk("cnt10",  32'(config_count), 32'd10);
      chk("full10", 32'(config_full),  32'd1);
      chk("cout10", 32'(config_out),   32'd1);

      select = 4'b0100;
      commit = 1'b1;
      step();
      commit = 1'b0;
      chk("c1_avalid", 32'(active_valid), 32'd1);
      chk("c1_cnt",    32'(config_count), 32'd0);
      chk("c1_full",   32'(config_full),  32'd0);
      chk("c1_err",    32'(commit_err),   32'd0);
      chk("c1_reg_lag", 32'(lut_out[1]),  32'd0);
      step();
      chk("c1_reg_now", 32'(lut_out[1]),  32'd1);

      for (int s = 0; s < 4; s++) begin
         sv = 2'(s);
         select = {2'b01, sv};
         #1;
         chk("and_comb", 32'(lut_out[0]), 32'(exp_and[s]));
      end
      select = 4'b0000;
      #1;
      chk("xor_hold", 32'(lut_out[1]), 32'd1);
      for (int s = 0; s < 4; s++) begin
         sv = 2'(s);
         select = {sv, 2'b00};
         step();
         chk("xor_reg", 32'(lut_out[1]), 32'(exp_xor[s]));
      end

      // Overflow: 12 shifts, count saturates, oldest bits leave on config_out
      for (int i = 11; i >= 0; i--) begin
         shift_bit(ovf[i]);
         if (i == 2) begin
            chk("ovf_cnt10",  32'(config_count), 32'd10);
            chk("ovf_cout10", 32'(config_out),   32'd0);
         end
         if (i == 1) begin
            chk("ovf_cnt11",  32'(config_count), 32'd10);
            chk("ovf_cout11", 32'(config_out),   32'd1);
         end
      end
      chk("ovf_cnt12",  32'(config_count), 32'd10);
      chk("ovf_cout12", 32'(config_out),   32'd0);
      chk("ovf_full",   32'(config_full),  32'd1);

      // Commit together with a shift: LUT1 = OR comb, LUT0 = NAND registered
      commit = 1'b1; config_valid = 1'b1; config_in = 1'b1;
      step();
      commit = 1'b0; config_valid = 1'b0; config_in = 1'b0;
      chk("cs_cnt",    32'(config_count), 32'd1);
      chk("cs_avalid", 32'(active_valid), 32'd1);
      chk("cs_err",    32'(commit_err),   32'd0);
      select = 4'b0000;
      #1;
      chk("or_sel0", 32'(lut_out[1]), 32'd0);
      select = 4'b1000;
      #1;
      chk("or_sel2", 32'(lut_out[1]), 32'd1);
      step();
      chk("nand_sel0", 32'(lut_out[0]), 32'd1);
      select = 4'b1011;
      #1;
      chk("nand_lag", 32'(lut_out[0]), 32'd1);
      step();
      chk("nand_sel3", 32'(lut_out[0]), 32'd0);
      chk("cs_cnt_hold", 32'(config_count), 32'd1);

      // Partial load then asynchronous reset
      for (int i = 0; i < 4; i++) shift_bit(1'b1);
      chk("pl_cnt", 32'(config_count), 32'd5);
      chk("pl_lut", 32'(lut_out), 32'd2);
      chk("pl_cout", 32'(config_out), 32'd1);
      #3 reset = 1'b1;
      #1;
      chk("mr_lut",    32'(lut_out),      32'd0);
      chk("mr_cnt",    32'(config_count), 32'd0);
      chk("mr_avalid", 32'(active_valid), 32'd0);
      chk("mr_cout",   32'(config_out),   32'd0);
      #2 reset = 1'b0;

      // Stream 3: LUT1 = XNOR comb, LUT0 = table 0010 comb
      for (int i = 9; i >= 1; i--) shift_bit(s3[i]);
      chk("s3_cnt9",  32'(config_count), 32'd9);
      chk("s3_full9", 32'(config_full),  32'd0);
      shift_bit(s3[0]);
      chk("s3_full10", 32'(config_full), 32'd1);
      commit = 1'b1;
      step();
      commit = 1'b0;
      chk("s3_avalid", 32'(active_valid), 32'd1);
      select = 4'b0000;
      #1;
      chk("s3_sel00", 32'(lut_out), 32'd2);
      select = 4'b1101;
      #1;
      chk("s3_sel31", 32'(lut_out), 32'd3);
      select = 4'b0110;
      #1;
      chk("s3_sel12", 32'(lut_out), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
